mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the unified memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    // Arbiter sequencing: pick a winner, hold the request until granted,
    // then wait for read data.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Which pipeline stage owns the outstanding memory transaction.
    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and
// the MEM stage. One transaction is outstanding at a time. MEM has fixed
// priority over IF. Done pulses and read data are registered.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    // fetch requester
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    // load/store requester
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    // memory side
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_t        state;
    arb_state_t        state_next;
    owner_t            owner;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              kill_q;

    logic mem_cand;
    logic if_cand;
    logic grant_mem;
    logic grant_if;
    logic finish;
    logic killed;
    logic deliver_if;
    logic deliver_mem;

    // A requester whose done is high this cycle is still holding its old
    // request, so it must not be picked again until the following cycle.
    assign mem_cand = mem_req && !mem_done;
    assign if_cand  = if_req && !if_kill && !if_done;

    // A fetch is abandoned if the flush arrived earlier or arrives now.
    assign killed      = kill_q || if_kill;
    assign deliver_if  = finish && (owner == OWN_IF) && !killed;
    assign deliver_mem = finish && (owner == OWN_MEM);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // values from before the edge; blocking (=) here would create ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle control strobes.
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        grant_mem  = 1'b0;
        grant_if   = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_cand) begin
                    grant_mem  = 1'b1;
                    state_next = REQ;
                end else if (if_cand) begin
                    grant_if   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (m_gnt) begin
                    if (we_q) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            RESP: begin
                if (m_rvalid) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the winning request; later changes on requester inputs are ignored.
    // NOTE: the datapath registers are reset too, so that m_* and the read data
    // outputs come out of reset as zero instead of X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner   <= OWN_IF;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (grant_mem) begin
            owner   <= OWN_MEM;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            we_q    <= mem_we;
        end else if (grant_if) begin
            owner   <= OWN_IF;
            addr_q  <= if_addr;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end
    end

    // Remember a flush of an in-flight fetch until the handshake finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kill_q <= 1'b0;
        end else if (finish) begin
            kill_q <= 1'b0;
        end else if ((state != IDLE) && (owner == OWN_IF) && if_kill) begin
            kill_q <= 1'b1;
        end
    end

    // One-cycle done pulses and held read data for each requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            if_done  <= deliver_if;
            mem_done <= deliver_mem;
            if (deliver_if && (state == RESP)) begin
                if_rdata <= m_rdata;
            end
            if (deliver_mem && (state == RESP)) begin
                mem_rdata <= m_rdata;
            end
        end
    end

    // Memory-side outputs come only from state and latched registers.
    assign m_req   = (state == REQ);
    assign m_we    = m_req && we_q;
    assign m_addr  = m_req ? addr_q  : '0;
    assign m_wdata = m_req ? wdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a reactive memory responder,
// per-requester scoreboards of expected read data, a vector table, and
// hand-written sequences for collision, backpressure, flush, reset, back-to-back.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_kill;
    logic          if_done;
    logic [DW-1:0] if_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_done;
    logic [DW-1:0] mem_rdata;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_gnt;
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_kill   (if_kill),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_gnt     (m_gnt),
        .m_rvalid  (m_rvalid),
        .m_rdata   (m_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory contents ----------------
    // mem_model is what the responder actually stores (from m_wdata/m_addr);
    // exp_model holds what the bench intended to store.
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] exp_model [logic [31:0]];

    function automatic logic [31:0] default_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (exp_model.exists(a)) return exp_model[a];
        return default_word(a);
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return default_word(a);
    endfunction

    // ---------------- memory responder ----------------
    int          gnt_delay = 0;
    int          rv_delay  = 0;
    int          r_phase   = 0;
    int          r_cnt     = 0;
    logic [31:0] r_addr;
    int          rvalid_count = 0;
    logic [32:0] gnt_log [$];

    initial begin
        m_gnt    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
        forever begin
            @(negedge clk);
            m_gnt    = 1'b0;
            m_rvalid = 1'b0;
            m_rdata  = 32'hBAAD_F00D;
            if (rst) begin
                r_phase = 0;
                r_cnt   = 0;
            end else if (r_phase == 0) begin
                if (!m_req) begin
                    r_cnt = 0;
                    check("m_idle_zero", {63'd0, (m_we || (|m_addr) || (|m_wdata))}, 64'd0);
                end else if (r_cnt == gnt_delay) begin
                    m_gnt = 1'b1;
                    gnt_log.push_back({m_we, m_addr});
                    if (m_we) begin
                        mem_model[m_addr] = m_wdata;
                    end else begin
                        r_addr  = m_addr;
                        r_phase = 1;
                    end
                    r_cnt = 0;
                end else begin
                    r_cnt++;
                end
            end else begin
                if (r_cnt == rv_delay) begin
                    m_rvalid = 1'b1;
                    m_rdata  = mem_read(r_addr);
                    rvalid_count++;
                    r_phase = 0;
                    r_cnt   = 0;
                end else begin
                    r_cnt++;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          is_read;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_if_q  [$];
    exp_t        exp_mem_q [$];
    exp_t        mon_e;
    logic [31:0] held_if  = '0;
    logic [31:0] held_mem = '0;
    int          if_done_cnt  = 0;
    int          mem_done_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (if_done || mem_done) begin
                    check("done_exclusive", {63'd0, (if_done && mem_done)}, 64'd0);
                end
                if (mem_done) begin
                    mem_done_cnt++;
                    check("mem_done_expected", {63'd0, (exp_mem_q.size() > 0)}, 64'd1);
                    if (exp_mem_q.size() > 0) begin
                        mon_e = exp_mem_q.pop_front();
                        if (mon_e.is_read) held_mem = mon_e.data;
                        check("mem_rdata", mem_rdata, held_mem);
                    end
                end
                if (if_done) begin
                    if_done_cnt++;
                    check("if_done_expected", {63'd0, (exp_if_q.size() > 0)}, 64'd1);
                    if (exp_if_q.size() > 0) begin
                        mon_e = exp_if_q.pop_front();
                        held_if = mon_e.data;
                        check("if_rdata", if_rdata, held_if);
                    end
                end
            end
        end
    end

    // ---------------- requester drivers (called at a negedge) ----------------
    task automatic wait_mem_done(input int start, output int lat);
        bit seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mem_done) begin
                seen = 1;
                break;
            end
        end
        check("mem_done_timeout", {63'd0, seen}, 64'd1);
        lat = cyc - start;
    endtask

    task automatic do_mem(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat);
        int   start;
        exp_t e;
        start     = cyc;
        e.is_read = !we;
        e.data    = we ? 32'h0 : exp_read(addr);
        if (we) exp_model[addr] = wdata;
        exp_mem_q.push_back(e);
        mem_req   = 1'b1;
        mem_we    = we;
        mem_addr  = addr;
        mem_wdata = wdata;
        wait_mem_done(start, lat);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
    endtask

    task automatic do_if(input logic [31:0] addr, output int lat);
        int   start;
        exp_t e;
        bit   seen = 0;
        start     = cyc;
        e.is_read = 1'b1;
        e.data    = exp_read(addr);
        exp_if_q.push_back(e);
        if_req  = 1'b1;
        if_addr = addr;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (if_done) begin
                seen = 1;
                break;
            end
        end
        check("if_done_timeout", {63'd0, seen}, 64'd1);
        lat     = cyc - start;
        if_req  = 1'b0;
        if_addr = '0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          is_mem;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gd;
        int          rd;
        int          lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_a;
        int lat_b;
        int t0;
        int cnt0;
        int rv0;
        int start;

        // read latency = 3 + grant stall + rvalid wait; write latency = 2 + grant stall
        vecs[0] = '{1'b1, 1'b0, 32'h10, 32'h0,    0, 0, 3};  // lone load -> DEADBEEF
        vecs[1] = '{1'b1, 1'b1, 32'h40, 32'h1234, 0, 0, 2};  // store
        vecs[2] = '{1'b1, 1'b0, 32'h40, 32'h0,    1, 2, 6};  // load back the store
        vecs[3] = '{1'b0, 1'b0, 32'h0,  32'h0,    0, 0, 3};  // fetch
        vecs[4] = '{1'b0, 1'b0, 32'h8,  32'h0,    2, 1, 6};  // fetch with stalls
        vecs[5] = '{1'b1, 1'b1, 32'h44, 32'hCAFE, 3, 0, 5};  // stalled store

        mem_model[32'h10] = 32'hDEAD_BEEF;
        exp_model[32'h10] = 32'hDEAD_BEEF;

        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        if_kill   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        repeat (2) @(negedge clk);
        check("reset_m_req",     {63'd0, m_req},    64'd0);
        check("reset_if_done",   {63'd0, if_done},  64'd0);
        check("reset_mem_done",  {63'd0, mem_done}, 64'd0);
        check("reset_if_rdata",  if_rdata,  64'd0);
        check("reset_mem_rdata", mem_rdata, 64'd0);
        check("reset_m_addr",    m_addr,    64'd0);
        rst = 1'b0;
        @(negedge clk);

        // table-driven transactions
        for (int i = 0; i < 6; i++) begin
            gnt_delay = vecs[i].gd;
            rv_delay  = vecs[i].rd;
            if (vecs[i].is_mem) do_mem(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat_a);
            else                do_if(vecs[i].addr, lat_a);
            check($sformatf("vec%0d_latency", i), lat_a, vecs[i].lat);
            @(negedge clk);
        end

        // collision: store wins, fetch sampled the cycle the store's done is high
        gnt_delay = 0;
        rv_delay  = 0;
        gnt_log.delete();
        fork
            do_mem(1'b1, 32'h20, 32'h55, lat_a);
            do_if(32'h0, lat_b);
        join
        check("coll_mem_latency", lat_a, 2);
        check("coll_if_latency",  lat_b, 5);
        check("coll_gnt_count",   gnt_log.size(), 2);
        if (gnt_log.size() >= 2) begin
            check("coll_first_is_store", gnt_log[0], {1'b1, 32'h20});
            check("coll_second_fetch",   gnt_log[1], {1'b0, 32'h0});
        end
        @(negedge clk);

        // grant backpressure on a fetch: grant in cycle 5, done in cycle 7
        gnt_delay = 4;
        fork
            do_if(32'h100, lat_a);
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("bp_m_req",  {63'd0, m_req}, 64'd1);
                    check("bp_m_addr", m_addr, 64'h100);
                end
            end
        join
        check("bp_if_latency", lat_a, 7);
        @(negedge clk);

        // flush during RESP: rvalid consumed, no if_done, if_rdata held
        gnt_delay = 0;
        rv_delay  = 2;
        cnt0      = if_done_cnt;
        rv0       = rvalid_count;
        if_req    = 1'b1;
        if_addr   = 32'h200;
        repeat (2) @(negedge clk);
        if_kill = 1'b1;
        if_req  = 1'b0;
        @(negedge clk);
        if_kill = 1'b0;
        repeat (3) @(negedge clk);
        check("flush_rvalid_consumed", rvalid_count - rv0, 1);
        check("flush_no_if_done",      if_done_cnt - cnt0, 0);
        check("flush_if_rdata_held",   if_rdata, held_if);
        check("flush_back_idle",       {63'd0, m_req}, 64'd0);
        rv_delay = 0;
        do_if(32'h204, lat_a);
        check("flush_next_fetch_latency", lat_a, 3);
        @(negedge clk);

        // asynchronous reset while stalled in REQ
        gnt_delay = 10;
        mem_req   = 1'b1;
        mem_we    = 1'b0;
        mem_addr  = 32'h10;
        repeat (2) @(negedge clk);
        check("rst_pre_m_req", {63'd0, m_req}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_m_req",     {63'd0, m_req},    64'd0);
        check("rst_m_addr",    m_addr,            64'd0);
        check("rst_mem_done",  {63'd0, mem_done}, 64'd0);
        check("rst_if_done",   {63'd0, if_done},  64'd0);
        check("rst_if_rdata",  if_rdata,          64'd0);
        check("rst_mem_rdata", mem_rdata,         64'd0);
        held_if   = '0;
        held_mem  = '0;
        gnt_delay = 0;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        start = cyc;
        exp_mem_q.push_back('{1'b1, 32'hDEAD_BEEF});
        wait_mem_done(start, lat_a);
        check("rst_rearb_latency", lat_a, 3);
        mem_req  = 1'b0;
        mem_addr = '0;
        @(negedge clk);

        // back-to-back loads: done pulses at cycles 3 and 7
        t0 = cyc;
        do_mem(1'b0, 32'h4, 32'h0, lat_a);
        check("b2b_first_done_cycle", cyc - t0, 3);
        do_mem(1'b0, 32'h8, 32'h0, lat_b);
        check("b2b_second_done_cycle", cyc - t0, 7);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_if_q.size() + exp_mem_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
